countdown_sprite_animator: RTL and testbench

Parametrised multi-frame sprite overlay for the VGA pipeline, the successor to the single-image full-screen stretch renderers. It plays an N-frame animation (3, 2, 1, FIGHT) from one sprite ROM, placing each frame at a run-time position with power-of-two integer scaling and a transparent colour key over the game's background pixel. A frame-sequencing state machine steps frames on video frame boundaries and reports completion to the game FSM.

---
 rtl/countdown_sprite_animator_if.sv | 41 ++++
 rtl/countdown_sprite_animator.sv | 149 ++++++++++++++
 tb/tb_countdown_sprite_animator.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/countdown_sprite_animator_if.sv
// Video, ROM and control signals shared between the countdown sprite animator
// and the surrounding VGA pipeline.
interface countdown_sprite_animator_if #(
  parameter int ADDR_W  = 15,
  parameter int IDX_W   = 2,
  parameter int FRAME_W = 2
);
  logic [9:0]         DrawX;
  logic [9:0]         DrawY;
  logic               blank;
  logic               frame_start;
  logic               start;
  logic [9:0]         pos_x;
  logic [9:0]         pos_y;
  logic [3:0]         bg_red;
  logic [3:0]         bg_green;
  logic [3:0]         bg_blue;
  logic [ADDR_W-1:0]  rom_address;
  logic [IDX_W-1:0]   rom_q;
  logic [3:0]         pal_red;
  logic [3:0]         pal_green;
  logic [3:0]         pal_blue;
  logic [3:0]         red;
  logic [3:0]         green;
  logic [3:0]         blue;
  logic               active;
  logic [FRAME_W-1:0] frame_idx;
  logic               done;

  modport master (
    output DrawX, DrawY, blank, frame_start, start, pos_x, pos_y,
    output bg_red, bg_green, bg_blue, rom_q, pal_red, pal_green, pal_blue,
    input  rom_address, red, green, blue, active, frame_idx, done
  );

  modport slave (
    input  DrawX, DrawY, blank, frame_start, start, pos_x, pos_y,
    input  bg_red, bg_green, bg_blue, rom_q, pal_red, pal_green, pal_blue,
    output rom_address, red, green, blue, active, frame_idx, done
  );
endinterface

// File: rtl/countdown_sprite_animator.sv
// Multi-frame scaled sprite overlay with colour-key transparency; a small FSM
// steps frames on video-frame boundaries and pulses done after the last one.
module countdown_sprite_animator #(
  parameter int SPR_W      = 100,
  parameter int SPR_H      = 50,
  parameter int FRAMES     = 4,
  parameter int SCALE_LOG2 = 1,
  parameter int HOLD       = 60,
  parameter int IDX_W      = 2,
  parameter int KEY_IDX    = 0,
  parameter int ADDR_W     = 15
) (
  input  logic                          vga_clk,
  input  logic                          reset,
  countdown_sprite_animator_if.slave    bus
);
  localparam int FRAME_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int HOLD_W   = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int WIN_W    = SPR_W << SCALE_LOG2;
  localparam int WIN_H    = SPR_H << SCALE_LOG2;
  localparam int FRAME_SZ = SPR_W * SPR_H;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               done_q, done_d;
  logic               active_q, active_d;

  function automatic logic [11:0] pick_pixel(input logic bl, input logic ov,
                                             input logic [11:0] pal,
                                             input logic [11:0] bg);
    if (!bl) return 12'd0;
    return ov ? pal : bg;
  endfunction

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      frame_q  <= '0;
      hold_q   <= '0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      active_q <= active_d;
    end
  end

  // start has priority over frame_start so a restart never also counts a hold tick
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (bus.start) begin
      state_d = S_PLAY;
      frame_d = '0;
      hold_d  = '0;
    end else if (state_q == S_PLAY && bus.frame_start) begin
      if (hold_q == HOLD_W'(HOLD - 1)) begin
        hold_d = '0;
        if (frame_q == FRAME_W'(FRAMES - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          frame_d = frame_q + 1'b1;
        end
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
    active_d = (state_d == S_PLAY);
  end

  logic [10:0]       dx, dy;
  logic              win;
  logic [ADDR_W-1:0] addr_d;

  assign dx     = {1'b0, bus.DrawX} - {1'b0, bus.pos_x};
  assign dy     = {1'b0, bus.DrawY} - {1'b0, bus.pos_y};
  assign win    = (dx < 11'(WIN_W)) && (dy < 11'(WIN_H));
  assign addr_d = ADDR_W'(FRAME_SZ * int'(frame_q) + SPR_W * int'(dy >> SCALE_LOG2)
                          + int'(dx >> SCALE_LOG2));

  logic [ADDR_W-1:0] rom_address_q;
  logic              win_p0_q, act_p0_q, blank_p0_q;
  logic [11:0]       bg_p0_q;
  logic              win_p1_q, act_p1_q, blank_p1_q;
  logic [11:0]       bg_p1_q;
  logic [11:0]       rgb_q;
  logic              overlay;

  // Stage 1: address and window flag registered alongside blank/bg/active
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_address_q <= '0;
      win_p0_q      <= 1'b0;
      act_p0_q      <= 1'b0;
      blank_p0_q    <= 1'b0;
      bg_p0_q       <= '0;
    end else begin
      rom_address_q <= addr_d;
      win_p0_q      <= win;
      act_p0_q      <= active_q;
      blank_p0_q    <= bus.blank;
      bg_p0_q       <= {bus.bg_red, bus.bg_green, bus.bg_blue};
    end
  end

  // Stage 2: ROM read in flight; control follows one more stage
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      win_p1_q   <= 1'b0;
      act_p1_q   <= 1'b0;
      blank_p1_q <= 1'b0;
      bg_p1_q    <= '0;
    end else begin
      win_p1_q   <= win_p0_q;
      act_p1_q   <= act_p0_q;
      blank_p1_q <= blank_p0_q;
      bg_p1_q    <= bg_p0_q;
    end
  end

  assign overlay = win_p1_q && act_p1_q && (bus.rom_q != IDX_W'(KEY_IDX));

  // Stage 3: final pixel
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= pick_pixel(blank_p1_q, overlay,
                          {bus.pal_red, bus.pal_green, bus.pal_blue}, bg_p1_q);
    end
  end

  assign bus.rom_address = rom_address_q;
  assign bus.red         = rgb_q[11:8];
  assign bus.green       = rgb_q[7:4];
  assign bus.blue        = rgb_q[3:0];
  assign bus.active      = active_q;
  assign bus.frame_idx   = frame_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_countdown_sprite_animator.sv
// Randomized bench for countdown_sprite_animator against a frame-count based
// reference model with an expected-pixel queue covering the 3-cycle latency.
module tb_countdown_sprite_animator;
  localparam int SPR_W      = 100;
  localparam int SPR_H      = 50;
  localparam int FRAMES     = 4;
  localparam int SCALE_LOG2 = 1;
  localparam int HOLD       = 2;
  localparam int IDX_W      = 2;
  localparam int KEY_IDX    = 0;
  localparam int ADDR_W     = 15;
  localparam int FRAME_W    = 2;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 vga_clk = ~vga_clk;

  countdown_sprite_animator_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .FRAME_W(FRAME_W)) bus();

  countdown_sprite_animator #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES), .SCALE_LOG2(SCALE_LOG2),
    .HOLD(HOLD), .IDX_W(IDX_W), .KEY_IDX(KEY_IDX), .ADDR_W(ADDR_W)
  ) dut (
    .vga_clk(vga_clk),
    .reset(reset),
    .bus(bus)
  );

  logic [IDX_W-1:0] rom_mem [0:(1<<ADDR_W)-1];

  always @(posedge vga_clk) bus.rom_q <= rom_mem[bus.rom_address];

  function automatic logic [11:0] pal_of(input logic [IDX_W-1:0] i);
    return {4'(i) + 4'd1, 4'(i) * 4'd3, 4'd15 - 4'(i)};
  endfunction

  assign {bus.pal_red, bus.pal_green, bus.pal_blue} = pal_of(bus.rom_q);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: animation is a count of frame_starts since the last start.
  bit          playing  = 1'b0;
  int          nfs      = 0;
  bit          exp_done = 1'b0;
  logic [11:0] expq[$];

  task automatic cyc(input bit rst_v, input bit st, input bit fs, input bit bl,
                     input int x, input int y, input int px, input int py,
                     input logic [11:0] bg);
    int   dxi, dyi, addr;
    bit   win, pl0;
    logic [11:0] e;
    reset           = rst_v;
    bus.start       = st;
    bus.frame_start = fs;
    bus.blank       = bl;
    bus.DrawX       = 10'(x);
    bus.DrawY       = 10'(y);
    bus.pos_x       = 10'(px);
    bus.pos_y       = 10'(py);
    {bus.bg_red, bus.bg_green, bus.bg_blue} = bg;

    dxi  = x - px;
    dyi  = y - py;
    win  = (dxi >= 0) && (dxi < SPR_W * (1 << SCALE_LOG2)) &&
           (dyi >= 0) && (dyi < SPR_H * (1 << SCALE_LOG2));
    pl0  = playing;
    addr = 0;
    if (win && pl0)
      addr = (nfs / HOLD) * SPR_W * SPR_H + (dyi / (1 << SCALE_LOG2)) * SPR_W
             + dxi / (1 << SCALE_LOG2);
    if (!bl) e = 12'd0;
    else if (win && pl0 && rom_mem[addr] != IDX_W'(KEY_IDX)) e = pal_of(rom_mem[addr]);
    else e = bg;
    expq.push_back(e);

    @(posedge vga_clk);
    exp_done = 1'b0;
    if (rst_v) begin
      playing = 1'b0;
      nfs     = 0;
    end else if (st) begin
      playing = 1'b1;
      nfs     = 0;
    end else if (playing && fs) begin
      nfs++;
      if (nfs == FRAMES * HOLD) begin
        playing  = 1'b0;
        exp_done = 1'b1;
      end
    end
    if (rst_v) foreach (expq[i]) expq[i] = 12'd0;

    @(negedge vga_clk);
    check_val("active", 32'(bus.active), 32'(playing));
    check_val("done", 32'(bus.done), 32'(exp_done));
    if (playing) check_val("frame_idx", 32'(bus.frame_idx), 32'(nfs / HOLD));
    if (rst_v) begin
      check_val("rst_frame_idx", 32'(bus.frame_idx), 32'd0);
      check_val("rst_rom_address", 32'(bus.rom_address), 32'd0);
    end else if (win && pl0) begin
      check_val("rom_address", 32'(bus.rom_address), 32'(addr));
    end
    if (expq.size() == 3)
      check_val("pixel", 32'({bus.red, bus.green, bus.blue}), 32'(expq.pop_front()));
  endtask

  task automatic idle(input int n, input int px, input int py);
    for (int i = 0; i < n; i++)
      cyc(0, 0, 0, 1, px + 10 + i, py + 10, px, py, 12'(i * 37));
  endtask

  initial begin
    int px, py, x, y;
    bit st, fs, rs, bl;
    for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = IDX_W'($urandom);
    rom_mem[0]    = IDX_W'(KEY_IDX);
    rom_mem[4999] = 2'd3;
    rom_mem[5000] = 2'd2;
    bus.start = 1'b0; bus.frame_start = 1'b0; bus.blank = 1'b0;
    bus.DrawX = '0; bus.DrawY = '0; bus.pos_x = '0; bus.pos_y = '0;
    {bus.bg_red, bus.bg_green, bus.bg_blue} = 12'd0;
    @(negedge vga_clk);

    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0, 12'd0);

    // Placement, key transparency, blanking, corners and outside pixels
    cyc(0, 1, 0, 1, 100, 100, 100, 100, 12'h567);
    cyc(0, 0, 0, 1, 100, 100, 100, 100, 12'h567);
    cyc(0, 0, 0, 0, 100, 100, 100, 100, 12'h567);
    cyc(0, 0, 0, 1, 299, 199, 100, 100, 12'h123);
    cyc(0, 0, 0, 1, 300, 100, 100, 100, 12'h9ab);
    cyc(0, 0, 0, 1, 99, 100, 100, 100, 12'hcde);
    cyc(0, 0, 0, 1, 299, 200, 100, 100, 12'h444);
    cyc(0, 0, 0, 1, 0, 10, 0, 0, 12'h0f0);

    // Screen-edge clipping at (600,460), including low-x pixels that must not wrap
    for (int i = 590; i < 640; i += 3) cyc(0, 0, 0, 1, i, 470, 600, 460, 12'(i));
    for (int j = 455; j < 480; j += 2) cyc(0, 0, 0, 1, 620, j, 600, 460, 12'(j));
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, i, 470, 600, 460, 12'h321);

    // Full sequence: 8 frame_starts run through all frames to DONE
    cyc(0, 1, 0, 1, 100, 100, 100, 100, 12'h111);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 1, 1, 150, 120, 100, 100, 12'h222);
      idle(2, 100, 100);
    end
    idle(4, 100, 100);

    // Restarts: mid-play, and start coincident with frame_start
    cyc(0, 1, 0, 1, 100, 100, 100, 100, 12'h111);
    repeat (3) cyc(0, 0, 1, 1, 120, 110, 100, 100, 12'h333);
    cyc(0, 1, 0, 1, 120, 110, 100, 100, 12'h333);
    cyc(0, 0, 1, 1, 120, 110, 100, 100, 12'h333);
    cyc(0, 1, 1, 1, 120, 110, 100, 100, 12'h333);
    cyc(0, 0, 1, 1, 120, 110, 100, 100, 12'h333);
    idle(3, 100, 100);

    // Reset in the middle of frame 2
    cyc(0, 1, 0, 1, 100, 100, 100, 100, 12'h111);
    repeat (4) cyc(0, 0, 1, 1, 130, 130, 100, 100, 12'h555);
    cyc(1, 0, 0, 1, 130, 130, 100, 100, 12'h555);
    idle(5, 100, 100);

    // Random traffic
    px = 100; py = 100;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        px = $urandom_range(0, 639);
        py = $urandom_range(0, 479);
      end
      x  = px + int'($urandom_range(0, 230)) - 15;
      y  = py + int'($urandom_range(0, 130)) - 15;
      if (x < 0) x = 0;
      if (x > 639) x = 639;
      if (y < 0) y = 0;
      if (y > 479) y = 479;
      st = ($urandom_range(0, 39) == 0);
      fs = ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 499) == 0);
      bl = ($urandom_range(0, 7) != 0);
      cyc(rs, st, fs, bl, x, y, px, py, 12'($urandom));
    end
    idle(3, 100, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
